ariane_irq_gateway_array: RTL and testbench

Parametrised interrupt gateway array between raw peripheral interrupt lines and the PLIC core. Each source gets its own gateway, which performs:
- an optional input synchroniser;
- per-source level/edge mode;
- a claim/complete handshake, so a source cannot re-request while its previous request is in flight;
- a saturating count of edge requests that arrive while the source is busy.

It replaces fixed uart/spi/eth/irq_i wiring with one generic N-source front end.

---
 rtl/ariane_irq_pkg.sv | 13 +
 rtl/ariane_irq_gateway_cell.sv | 113 +++++++++++
 rtl/ariane_irq_gateway_array.sv | 55 +++++
 tb/tb_ariane_irq_gateway_array.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ariane_irq_pkg.sv
// Shared types and default sizing for the interrupt gateway array.
package ariane_irq_pkg;

  typedef enum logic [1:0] {
    GW_IDLE     = 2'd0,
    GW_PENDING  = 2'd1,
    GW_INFLIGHT = 2'd2
  } gw_state_e;

  localparam int unsigned DEF_NR_SRC     = 32;
  localparam int unsigned DEF_PEND_CNT_W = 2;

endpackage

// File: rtl/ariane_irq_gateway_cell.sv
// One interrupt source: synchroniser, edge detect, claim/complete FSM,
// queued-edge counter and sticky overflow flag.
//   state       | meaning
//   GW_IDLE     | no request outstanding
//   GW_PENDING  | request visible to the PLIC, waiting for a claim
//   GW_INFLIGHT | claimed, waiting for the completion
module ariane_irq_gateway_cell
  import ariane_irq_pkg::*;
#(
  parameter bit          EDGE_MODE   = 1'b0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PEND_CNT_W  = 2
) (
  input  logic aclk,
  input  logic areset,
  input  logic irq,
  input  logic claim,
  input  logic complete,
  input  logic overflow_clr,
  output logic pending,
  output logic inflight,
  output logic overflow
);

  localparam logic [PEND_CNT_W-1:0] CNT_MAX = '1;

  gw_state_e             state_q, state_d;
  logic [PEND_CNT_W-1:0] cnt_q, cnt_d;
  logic                  ovf_q, ovf_set;
  logic                  line_s, prev_q, rise_q;
  logic                  req, edge_evt;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge aclk) begin
        if (areset) sync_q <= '0;
        else        sync_q <= (sync_q << 1) | SYNC_STAGES'(irq);
      end
      assign line_s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign line_s = irq;
    end
  endgenerate

  // Rise is registered, so edge mode costs one cycle more than level mode.
  always_ff @(posedge aclk) begin
    if (areset) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= line_s;
      rise_q <= line_s & ~prev_q;
    end
  end

  assign edge_evt = EDGE_MODE & rise_q;
  assign req      = EDGE_MODE ? rise_q : line_s;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= GW_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_set | (ovf_q & ~overflow_clr);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    case (state_q)
      GW_IDLE: begin
        if (req) state_d = GW_PENDING;
      end
      GW_PENDING: begin
        if (claim) state_d = GW_INFLIGHT;
        if (edge_evt) begin
          if (cnt_q == CNT_MAX) ovf_set = 1'b1;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      GW_INFLIGHT: begin
        if (complete) begin
          // A fresh edge together with a complete cancels the decrement.
          if (edge_evt) begin
            state_d = GW_PENDING;
          end else if (cnt_q != '0) begin
            state_d = GW_PENDING;
            cnt_d   = cnt_q - 1'b1;
          end else begin
            state_d = GW_IDLE;
          end
        end else if (edge_evt) begin
          if (cnt_q == CNT_MAX) ovf_set = 1'b1;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = GW_IDLE;
    endcase
  end

  always_comb begin
    pending  = (state_q == GW_PENDING);
    inflight = (state_q == GW_INFLIGHT);
    overflow = ovf_q;
  end

endmodule

// File: rtl/ariane_irq_gateway_array.sv
// Generic N-source interrupt gateway front end; source 0 is reserved and
// permanently idle.
module ariane_irq_gateway_array
  import ariane_irq_pkg::*;
#(
  parameter int unsigned        NR_SRC      = DEF_NR_SRC,
  parameter int unsigned        SRC_ID_W    = $clog2(NR_SRC),
  parameter logic [NR_SRC-1:0]  EDGE_MASK   = '0,
  parameter int unsigned        SYNC_STAGES = 2,
  parameter int unsigned        PEND_CNT_W  = DEF_PEND_CNT_W
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [NR_SRC-1:0]   irq_src_i,
  input  logic                claim_valid_i,
  input  logic [SRC_ID_W-1:0] claim_id_i,
  input  logic                complete_valid_i,
  input  logic [SRC_ID_W-1:0] complete_id_i,
  output logic [NR_SRC-1:0]   pending_o,
  output logic [NR_SRC-1:0]   inflight_o,
  output logic [NR_SRC-1:0]   overflow_o,
  input  logic                overflow_clr_i
);

  logic unused_src0;
  assign unused_src0 = irq_src_i[0];

  assign pending_o[0]  = 1'b0;
  assign inflight_o[0] = 1'b0;
  assign overflow_o[0] = 1'b0;

  // IDs 0 and >= NR_SRC match no cell, so they fall through silently.
  for (genvar i = 1; i < NR_SRC; i++) begin : g_gw
    logic claim_hit, complete_hit;
    assign claim_hit    = claim_valid_i    && (claim_id_i    == SRC_ID_W'(i));
    assign complete_hit = complete_valid_i && (complete_id_i == SRC_ID_W'(i));

    ariane_irq_gateway_cell #(
      .EDGE_MODE   (EDGE_MASK[i]),
      .SYNC_STAGES (SYNC_STAGES),
      .PEND_CNT_W  (PEND_CNT_W)
    ) u_cell (
      .aclk         (aclk),
      .areset       (areset),
      .irq          (irq_src_i[i]),
      .claim        (claim_hit),
      .complete     (complete_hit),
      .overflow_clr (overflow_clr_i),
      .pending      (pending_o[i]),
      .inflight     (inflight_o[i]),
      .overflow     (overflow_o[i])
    );
  end

endmodule

// File: tb/tb_ariane_irq_gateway_array.sv
// Directed bench for the gateway array: 12 sources, edge mode on 3, 6 and 9.
module tb_ariane_irq_gateway_array;

  localparam int NR_SRC = 12;
  localparam int IDW    = 4;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NR_SRC-1:0] irq_src;
  logic              claim_valid, complete_valid, overflow_clr;
  logic [IDW-1:0]    claim_id, complete_id;
  logic [NR_SRC-1:0] pending, inflight, overflow;

  int n_err = 0;
  int n_chk = 0;

  always #5 aclk = ~aclk;

  ariane_irq_gateway_array #(
    .NR_SRC      (NR_SRC),
    .SRC_ID_W    (IDW),
    .EDGE_MASK   (12'h248),
    .SYNC_STAGES (2),
    .PEND_CNT_W  (2)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .irq_src_i        (irq_src),
    .claim_valid_i    (claim_valid),
    .claim_id_i       (claim_id),
    .complete_valid_i (complete_valid),
    .complete_id_i    (complete_id),
    .pending_o        (pending),
    .inflight_o       (inflight),
    .overflow_o       (overflow),
    .overflow_clr_i   (overflow_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_claim(input int id);
    claim_valid = 1'b1; claim_id = IDW'(id);
    tick(1);
    claim_valid = 1'b0;
  endtask

  task automatic do_complete(input int id);
    complete_valid = 1'b1; complete_id = IDW'(id);
    tick(1);
    complete_valid = 1'b0;
  endtask

  // One-cycle pulse, then enough cycles for its edge to reach the FSM.
  task automatic pulse(input int i);
    irq_src[i] = 1'b1;
    tick(1);
    irq_src[i] = 1'b0;
    tick(3);
  endtask

  initial begin
    areset = 1'b1; irq_src = '0; claim_valid = 1'b0; complete_valid = 1'b0;
    claim_id = '0; complete_id = '0; overflow_clr = 1'b0;
    tick(3);
    chk("rst_pending",  32'(pending),  32'h0);
    chk("rst_inflight", 32'(inflight), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    areset = 1'b0;
    tick(2);

    // level source 5
    irq_src[5] = 1'b1;
    tick(2);
    chk("lvl_lat_early", 32'(pending), 32'h0);
    tick(1);
    chk("lvl_lat", 32'(pending), 32'h020);
    do_claim(5);
    chk("lvl_claim_pend", 32'(pending),  32'h0);
    chk("lvl_claim_infl", 32'(inflight), 32'h020);
    do_complete(5);
    chk("lvl_cmp_infl", 32'(inflight), 32'h0);
    chk("lvl_cmp_idle", 32'(pending),  32'h0);
    tick(1);
    chk("lvl_rearm", 32'(pending), 32'h020);
    irq_src[5] = 1'b0;
    do_claim(5);
    do_complete(5);
    tick(2);
    chk("lvl_clean", 32'(pending | inflight), 32'h0);

    // edge source 3: latency, saturation, drain, clear
    irq_src[3] = 1'b1;
    tick(1);
    irq_src[3] = 1'b0;
    tick(2);
    chk("edge_lat_early", 32'(pending), 32'h0);
    tick(1);
    chk("edge_lat", 32'(pending), 32'h008);
    do_claim(3);
    pulse(3); pulse(3); pulse(3);
    chk("edge_no_ovf", 32'(overflow), 32'h0);
    pulse(3);
    chk("edge_ovf",  32'(overflow), 32'h008);
    chk("edge_busy", 32'(inflight), 32'h008);
    for (int k = 0; k < 3; k++) begin
      do_complete(3);
      chk($sformatf("edge_drain%0d", k), 32'(pending), 32'h008);
      do_claim(3);
    end
    do_complete(3);
    chk("edge_idle", 32'(pending | inflight), 32'h0);
    chk("ovf_sticky", 32'(overflow), 32'h008);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'h0);

    // ignored claims / completes
    do_claim(0); do_claim(7); do_claim(13);
    chk("ign_claim_idle", 32'(pending | inflight), 32'h0);
    irq_src[4] = 1'b1;
    tick(3);
    chk("src4_pend", 32'(pending), 32'h010);
    do_claim(0); do_claim(13);
    chk("ign_claim_pend", 32'(inflight), 32'h0);
    do_complete(4);
    chk("ign_cmp_pend", 32'(pending), 32'h010);
    chk("ign_cmp_infl", 32'(inflight), 32'h0);

    // simultaneous claim 2 / complete 4
    irq_src[2] = 1'b1;
    tick(3);
    chk("two_pend", 32'(pending), 32'h014);
    do_claim(4);
    chk("src4_infl", 32'(inflight), 32'h010);
    irq_src[4] = 1'b0;
    tick(2);
    claim_valid = 1'b1; claim_id = 4'd2;
    complete_valid = 1'b1; complete_id = 4'd4;
    tick(1);
    claim_valid = 1'b0; complete_valid = 1'b0;
    chk("sim_infl", 32'(inflight), 32'h004);
    chk("sim_pend", 32'(pending),  32'h0);

    // source 6: complete and new edge together with counter 0
    pulse(6);
    chk("src6_pend", 32'(pending), 32'h040);
    do_claim(6);
    irq_src[6] = 1'b1;
    tick(1);
    irq_src[6] = 1'b0;
    tick(2);
    do_complete(6);
    chk("cmp_edge_pend", 32'(pending),  32'h040);
    chk("cmp_edge_infl", 32'(inflight), 32'h004);
    do_claim(6);
    do_complete(6);
    chk("cmp_edge_cnt0", 32'(pending), 32'h0);
    irq_src[2] = 1'b0;
    tick(2);
    do_complete(2);
    tick(2);
    chk("sim_clean", 32'(pending | inflight), 32'h0);

    // source 9: line held high through reset, then reset mid-flight
    irq_src[9] = 1'b1;
    areset = 1'b1;
    tick(2);
    areset = 1'b0;
    chk("hold_rst", 32'(pending), 32'h0);
    tick(3);
    chk("hold_early", 32'(pending), 32'h0);
    tick(1);
    chk("hold_edge", 32'(pending), 32'h200);
    irq_src[9] = 1'b0;
    do_claim(9);
    tick(2);
    pulse(9); pulse(9);
    chk("s9_infl", 32'(inflight), 32'h200);
    chk("s9_no_ovf", 32'(overflow), 32'h0);
    areset = 1'b1;
    tick(1);
    chk("abort_pend", 32'(pending),  32'h0);
    chk("abort_infl", 32'(inflight), 32'h0);
    areset = 1'b0;
    tick(4);
    chk("abort_idle", 32'(pending | inflight | overflow), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
